// File: rtl/divider_unsigned_iter_4b_pkg.sv
// Shared constants and state encoding for the iterative 4-bit divider.
`timescale 1ns/1ps
package divider_unsigned_iter_4b_pkg;
    localparam int NBITS      = 4;
    localparam int CNT_W      = 2;
    localparam int ITER_COUNT = 4;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_CALC = 2'd1,
        STATE_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/divider_unsigned_iter_4b_if.sv
// Request/result val/rdy bundle between producer, divider and consumer.
`timescale 1ns/1ps
interface divider_unsigned_iter_4b_if;
    import divider_unsigned_iter_4b_pkg::*;

    logic             istream_val;
    logic             istream_rdy;
    logic [NBITS-1:0] dividend;
    logic [NBITS-1:0] divisor;
    logic             ostream_val;
    logic             ostream_rdy;
    logic [NBITS-1:0] quotient;
    logic [NBITS-1:0] remainder;
    logic             divbyzero;

    // master = request producer / result consumer side
    modport master (
        output istream_val, dividend, divisor, ostream_rdy,
        input  istream_rdy, ostream_val, quotient, remainder, divbyzero
    );

    // slave = the divider
    modport slave (
        input  istream_val, dividend, divisor, ostream_rdy,
        output istream_rdy, ostream_val, quotient, remainder, divbyzero
    );
endinterface

// File: rtl/divider_unsigned_iter_4b_dpath.sv
// Divider datapath: q/r/d registers, shift mux and the ripple-carry subtractor.
`timescale 1ns/1ps

// Gate-level 4-bit ripple-borrow subtractor: diff = in0 - in1 - bin.
module subtractor_ripple_carry_4b_gl (
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout
);
    logic [4:0] borrow;

    assign borrow[0] = bin;
    for (genvar i = 0; i < 4; i++) begin : g_fs
        assign diff[i]     = in0[i] ^ in1[i] ^ borrow[i];
        assign borrow[i+1] = (~in0[i] & in1[i]) | (~(in0[i] ^ in1[i]) & borrow[i]);
    end
    assign bout = borrow[4];
endmodule

module divider_unsigned_iter_4b_dpath
    import divider_unsigned_iter_4b_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             calc,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] d,
    output logic [NBITS-1:0] q,
    output logic [NBITS-1:0] r,
    output logic             dbz
);
    logic [NBITS-1:0] q_reg, r_reg, d_reg;
    logic             dbz_reg;
    logic [NBITS:0]   shifted;
    logic [NBITS-1:0] diff;
    logic             bout;
    logic             qbit;

    assign shifted = {r_reg, q_reg[NBITS-1]};

    subtractor_ripple_carry_4b_gl u_sub (
        .in0  (shifted[NBITS-1:0]),
        .in1  (d_reg),
        .bin  (1'b0),
        .diff (diff),
        .bout (bout)
    );

    // A set top bit means shifted >= 16 > D, so the borrow is meaningless then.
    assign qbit = shifted[NBITS] | ~bout;

    // Load operands on handshake, then one restoring step per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg   <= '0;
            r_reg   <= '0;
            d_reg   <= '0;
            dbz_reg <= 1'b0;
        end else if (load) begin
            q_reg   <= a;
            d_reg   <= d;
            r_reg   <= '0;
            dbz_reg <= (d == '0);
        end else if (calc) begin
            r_reg <= qbit ? diff : shifted[NBITS-1:0];
            q_reg <= {q_reg[NBITS-2:0], qbit};
        end
    end

    assign q   = q_reg;
    assign r   = r_reg;
    assign dbz = dbz_reg;
endmodule

// File: rtl/divider_unsigned_iter_4b.sv
// Iterative 4-bit unsigned restoring divider: control FSM and step counter.
`timescale 1ns/1ps
module divider_unsigned_iter_4b
    import divider_unsigned_iter_4b_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    divider_unsigned_iter_4b_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             load, calc, in_rdy, out_val;

    // State register and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STATE_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (load)
                cnt <= '0;
            else if (calc)
                cnt <= cnt + 1'b1;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        in_rdy     = 1'b0;
        out_val    = 1'b0;
        load       = 1'b0;
        calc       = 1'b0;
        case (state)
            STATE_IDLE: begin
                in_rdy = 1'b1;
                if (bus.istream_val) begin
                    load       = 1'b1;
                    state_next = STATE_CALC;
                end
            end
            STATE_CALC: begin
                calc = 1'b1;
                if (cnt == CNT_LAST)
                    state_next = STATE_DONE;
            end
            STATE_DONE: begin
                out_val = 1'b1;
                if (bus.ostream_rdy)
                    state_next = STATE_IDLE;
            end
            default: state_next = STATE_IDLE;
        endcase
    end

    divider_unsigned_iter_4b_dpath u_dpath (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .calc (calc),
        .a    (bus.dividend),
        .d    (bus.divisor),
        .q    (bus.quotient),
        .r    (bus.remainder),
        .dbz  (bus.divbyzero)
    );

    assign bus.istream_rdy = in_rdy;
    assign bus.ostream_val = out_val;
endmodule

// File: tb/tb_divider_unsigned_iter_4b.sv
// Self-checking bench for the iterative 4-bit divider.
`timescale 1ns/1ps
module tb_divider_unsigned_iter_4b;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    divider_unsigned_iter_4b_if bus ();

    divider_unsigned_iter_4b dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic, with divide-by-zero giving all-ones / A.
    function automatic logic [3:0] ref_q(input int a, input int d);
        return (d == 0) ? 4'hF : 4'(a / d);
    endfunction
    function automatic logic [3:0] ref_r(input int a, input int d);
        return (d == 0) ? 4'(a) : 4'(a % d);
    endfunction

    // Issue one request, check latency and result, stall `stall` cycles in DONE
    // (poking istream_val meanwhile when `poke` is set), then release.
    task automatic run_op(input int a, input int d, input int stall, input bit poke);
        int n;
        logic [3:0] eq, er;
        eq = ref_q(a, d);
        er = ref_r(a, d);
        n = 0;
        while (!bus.istream_rdy && n < 20) begin @(negedge clk); n++; end
        check("req_rdy", 8'(bus.istream_rdy), 8'd1);
        bus.istream_val = 1'b1;
        bus.dividend    = 4'(a);
        bus.divisor     = 4'(d);
        @(negedge clk);
        bus.istream_val = 1'b0;
        bus.dividend    = 4'($urandom);
        bus.divisor     = 4'($urandom);
        n = 1;
        while (!bus.ostream_val && n < 20) begin @(negedge clk); n++; end
        check("latency", 8'(n), 8'd5);
        check("quotient", 8'(bus.quotient), 8'(eq));
        check("remainder", 8'(bus.remainder), 8'(er));
        check("divbyzero", 8'(bus.divbyzero), 8'(d == 0));
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                bus.istream_val = 1'b1;
                bus.dividend    = 4'd1;
                bus.divisor     = 4'd1;
            end
            @(negedge clk);
            check("hold_val", 8'(bus.ostream_val), 8'd1);
            check("hold_q", 8'(bus.quotient), 8'(eq));
            check("hold_r", 8'(bus.remainder), 8'(er));
            check("hold_busy", 8'(bus.istream_rdy), 8'd0);
        end
        bus.istream_val = 1'b0;
        bus.ostream_rdy = 1'b1;
        @(negedge clk);
        bus.ostream_rdy = 1'b0;
        check("post_oval", 8'(bus.ostream_val), 8'd0);
        check("post_rdy", 8'(bus.istream_rdy), 8'd1);
    endtask

    initial begin
        bus.istream_val = 1'b0;
        bus.dividend    = '0;
        bus.divisor     = '0;
        bus.ostream_rdy = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_rdy", 8'(bus.istream_rdy), 8'd1);
        check("rst_oval", 8'(bus.ostream_val), 8'd0);
        check("rst_q", 8'(bus.quotient), 8'd0);
        check("rst_r", 8'(bus.remainder), 8'd0);
        check("rst_dbz", 8'(bus.divbyzero), 8'd0);

        // Directed cases
        run_op(13, 3, 0, 1'b0);
        run_op(15, 1, 0, 1'b0);
        run_op(14, 15, 0, 1'b0);
        run_op(15, 2, 0, 1'b0);
        run_op(7, 0, 0, 1'b0);
        // Stall three cycles in DONE while a new request is offered
        run_op(11, 5, 3, 1'b1);

        // Reset in the second CALC cycle discards the op
        bus.istream_val = 1'b1;
        bus.dividend    = 4'd12;
        bus.divisor     = 4'd5;
        @(negedge clk);
        bus.istream_val = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_oval", 8'(bus.ostream_val), 8'd0);
        check("midrst_rdy", 8'(bus.istream_rdy), 8'd1);
        check("midrst_q", 8'(bus.quotient), 8'd0);
        run_op(9, 4, 0, 1'b0);

        // Reset wins over a simultaneous handshake
        rst = 1'b1;
        bus.istream_val = 1'b1;
        bus.dividend    = 4'd6;
        bus.divisor     = 4'd2;
        @(negedge clk);
        rst = 1'b0;
        bus.istream_val = 1'b0;
        check("rstwin_rdy", 8'(bus.istream_rdy), 8'd1);
        @(negedge clk);
        check("rstwin_idle", 8'(bus.ostream_val), 8'd0);

        // Exhaustive sweep with random consumer stalls
        for (int a = 0; a < 16; a++)
            for (int d = 0; d < 16; d++)
                run_op(a, d, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

        // A handful of fully random ops
        for (int k = 0; k < 20; k++)
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
